mem_port_arbiter: RTL and testbench

- Shares the CPU's single memory bus between two requesters: the instruction-fetch path (IorD=0) and the load/store data path (IorD=1).
- Registers the bus command, waits on waitrequest, and returns read data with a one-cycle done pulse.
- Drives the stall input of the control FSM while any access is outstanding.
- Arbitrates round-robin when both requesters are pending, and faults misaligned or hung accesses.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store, with
// round-robin arbitration, alignment faults and a waitrequest timeout.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 1024,
  parameter int unsigned CNT_W    = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        fault,
  output logic        stall,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUS_IF = 2'd1;
  localparam logic [1:0] BUS_D  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  logic [1:0]       state;
  logic             last_grant;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             grant_any;
  logic             grant_d;
  logic             grant_fault;
  logic             timeout;
  logic             in_fetch;

  function automatic logic is_onehot4(input logic [3:0] be);
    return (be != 4'b0000) && ((be & (be - 4'd1)) == 4'b0000);
  endfunction

  // Word accesses must be aligned; sub-word accesses must name exactly one lane.
  function automatic logic data_misaligned(input logic [1:0] lsb, input logic [3:0] be);
    if (be == 4'b1111) return lsb != 2'b00;
    return !is_onehot4(be);
  endfunction

  always_comb begin
    grant_any = if_req | d_req;
    if (if_req && d_req) grant_d = (last_grant == GRANT_IF);
    else                 grant_d = d_req;
    grant_fault = grant_d ? data_misaligned(d_addr[1:0], d_byteen)
                          : (if_addr[1:0] != 2'b00);
  end

  assign wait_cnt_nxt = wait_cnt + 1'b1;
  assign timeout      = (MAX_WAIT != 0) && (32'(wait_cnt_nxt) == MAX_WAIT);
  assign in_fetch     = (state == BUS_IF);
  assign stall        = (if_req | d_req) & ~(if_done | d_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      wait_cnt   <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      fault      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      fault   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            if (if_req && d_req) last_grant <= grant_d;
            if (grant_d) begin
              address    <= {d_addr[31:2], 2'b00};
              writedata  <= d_wdata;
              byteenable <= d_byteen;
            end else begin
              address    <= {if_addr[31:2], 2'b00};
              byteenable <= 4'b1111;
            end
            // A faulting grant never reaches the bus.
            if (grant_fault) begin
              state   <= DONE;
              fault   <= 1'b1;
              if_done <= !grant_d;
              d_done  <= grant_d;
            end else begin
              state <= grant_d ? BUS_D : BUS_IF;
              read  <= !grant_d || !d_write;
              write <= grant_d && d_write;
            end
          end
        end
        BUS_IF, BUS_D: begin
          if (!waitrequest) begin
            if (read) begin
              if (in_fetch) if_rdata <= readdata;
              else          d_rdata  <= readdata;
            end
            read    <= 1'b0;
            write   <= 1'b0;
            state   <= DONE;
            if_done <= in_fetch;
            d_done  <= !in_fetch;
          end else begin
            wait_cnt <= wait_cnt_nxt;
            if (timeout) begin
              read    <= 1'b0;
              write   <= 1'b0;
              state   <= DONE;
              fault   <= 1'b1;
              if_done <= in_fetch;
              d_done  <= !in_fetch;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle expectation table is filled
// from transaction-level rules and compared against the DUT every cycle.
module tb_mem_port_arbiter;

  localparam int MAXW = 4;
  localparam int NC   = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        fault;
  logic        stall;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  mem_port_arbiter #(.MAX_WAIT(MAXW), .CNT_W(11)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteen(d_byteen), .d_done(d_done), .d_rdata(d_rdata),
    .fault(fault), .stall(stall),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs indexed by cycle number (the cycle following edge N).
  bit        exp_rd   [NC];
  bit        exp_wr   [NC];
  bit [31:0] exp_addr [NC];
  bit [31:0] exp_wd   [NC];
  bit [3:0]  exp_be   [NC];
  bit        exp_ifd  [NC];
  bit        exp_dd   [NC];
  bit        exp_flt  [NC];
  bit [31:0] exp_ifr  [NC];
  bit [31:0] exp_dr   [NC];

  int n_vec = 0;
  int n_err = 0;
  int n_rd_cyc = 0;
  int n_wr_cyc = 0;
  int n_flt = 0;
  int if_done_cyc = -1;
  int d_done_cyc = -1;
  bit m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic bit pick(input bit fi, input bit fd);
    bit w;
    if (fi && fd) begin
      w = ~m_last;
      m_last = w;
    end else begin
      w = fd;
    end
    return w;
  endfunction

  task automatic schedule(input bit who, input bit [31:0] a, input bit wr,
                          input bit [31:0] wd, input bit [3:0] be, input bit [31:0] rd,
                          input int nw, input int ge, output int td);
    bit flt, tmo, is_rd;
    if (!who) begin
      flt = (a[1:0] != 2'b00);
      is_rd = 1'b1;
    end else begin
      flt = (be == 4'hF) ? (a[1:0] != 2'b00) : ($countones(be) != 1);
      is_rd = !wr;
    end
    tmo = !flt && (MAXW != 0) && (nw >= MAXW);
    if (flt)      td = ge;
    else if (tmo) td = ge + MAXW;
    else          td = ge + nw + 1;
    if (td >= NC - 4) begin
      $display("FAIL schedule: cycle %0d beyond table, limit %0d", td, NC - 4);
      $fatal(1);
    end
    for (int c = ge; c < td; c++) begin
      exp_rd[c]   = is_rd;
      exp_wr[c]   = !is_rd;
      exp_addr[c] = {a[31:2], 2'b00};
      exp_wd[c]   = wd;
      exp_be[c]   = who ? be : 4'hF;
    end
    if (who) exp_dd[td] = 1'b1;
    else     exp_ifd[td] = 1'b1;
    exp_flt[td] = flt | tmo;
    if (is_rd && !flt && !tmo)
      for (int c = td; c < NC; c++) begin
        if (who) exp_dr[c] = rd;
        else     exp_ifr[c] = rd;
      end
  endtask

  task automatic sched_req(input bit who, input int ge, input int nw, output int td);
    if (who) schedule(1'b1, d_addr, d_write, d_wdata, d_byteen, readdata, nw, ge, td);
    else     schedule(1'b0, if_addr, 1'b0, 32'h0, 4'hF, readdata, nw, ge, td);
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < NC; c++) begin
      exp_rd[c] = 0; exp_wr[c] = 0; exp_ifd[c] = 0; exp_dd[c] = 0; exp_flt[c] = 0;
      exp_ifr[c] = 0; exp_dr[c] = 0;
    end
  endtask

  task automatic drive_wait(input int ge, input int nw, input int td);
    while (cyc < td) begin
      waitrequest = (cyc >= ge) && (cyc < ge + nw);
      @(posedge clk); #1;
    end
    waitrequest = 1'b0;
  endtask

  task automatic run1(input bit who, input bit [31:0] a, input bit wr, input bit [31:0] wd,
                      input bit [3:0] be, input bit [31:0] rd, input int nw,
                      output int ge, output int td);
    readdata = rd;
    if (who) begin
      d_req = 1'b1; d_addr = a; d_write = wr; d_wdata = wd; d_byteen = be;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    ge = cyc + 1;
    sched_req(who, ge, nw, td);
    drive_wait(ge, nw, td);
    if (who) d_req = 1'b0;
    else     if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (cyc < NC) begin
      chk("read", 32'(read), 32'(exp_rd[cyc]));
      chk("write", 32'(write), 32'(exp_wr[cyc]));
      if (exp_rd[cyc] || exp_wr[cyc]) begin
        chk("address", address, exp_addr[cyc]);
        chk("byteenable", 32'(byteenable), 32'(exp_be[cyc]));
      end
      if (exp_wr[cyc]) chk("writedata", writedata, exp_wd[cyc]);
      chk("if_done", 32'(if_done), 32'(exp_ifd[cyc]));
      chk("d_done", 32'(d_done), 32'(exp_dd[cyc]));
      chk("fault", 32'(fault), 32'(exp_flt[cyc]));
      chk("if_rdata", if_rdata, exp_ifr[cyc]);
      chk("d_rdata", d_rdata, exp_dr[cyc]);
      chk("stall", 32'(stall), 32'((if_req | d_req) & ~(exp_ifd[cyc] | exp_dd[cyc])));
      chk("strobe_excl", 32'(read & write), 32'h0);
      chk("done_excl", 32'(if_done & d_done), 32'h0);
      if (read) n_rd_cyc++;
      if (write) n_wr_cyc++;
      if (fault) n_flt++;
      if (if_done) if_done_cyc = cyc;
      if (d_done) d_done_cyc = cyc;
    end
  end

  initial begin
    int ge, td, ge1, ge2, ge3, w, base_rd, base_wr, base_flt;
    reset = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_write = 0; d_addr = 0; d_wdata = 0;
    d_byteen = 0; readdata = 0; waitrequest = 0;
    m_last = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_address", address, 32'h0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);

    // Boot fetch, no wait states.
    base_rd = n_rd_cyc;
    run1(1'b0, 32'hBFC00000, 1'b0, 32'h0, 4'hF, 32'h24080005, 0, ge, td);
    chk("fetch_latency", 32'(if_done_cyc - ge), 32'd1);
    chk("fetch_rdata_lit", if_rdata, 32'h24080005);
    chk("fetch_read_cycles", 32'(n_rd_cyc - base_rd), 32'd1);

    // Store with three wait states.
    base_wr = n_wr_cyc;
    run1(1'b1, 32'h00001004, 1'b1, 32'hDEADBEEF, 4'hF, 32'hCAFEF00D, 3, ge, td);
    chk("store_latency", 32'(d_done_cyc - ge), 32'd4);
    chk("store_write_cycles", 32'(n_wr_cyc - base_wr), 32'd4);
    chk("store_d_rdata_lit", d_rdata, 32'h0);

    // Contention: fetch first, the re-raised fetch loses to held data, then fetch alone.
    if_req = 1'b1; if_addr = 32'h00000100;
    d_req = 1'b1; d_addr = 32'h00003000; d_write = 1'b0; d_wdata = 32'h0; d_byteen = 4'hF;
    readdata = 32'hA1A1A1A1;
    ge1 = cyc + 1;
    w = int'(pick(if_req, d_req));
    chk("rr_first_model", 32'(w), 32'd0);
    sched_req(w[0], ge1, 0, td);
    drive_wait(ge1, 0, td);
    if (w[0]) d_req = 1'b0; else if_req = 1'b0;
    @(posedge clk); #1;
    if (w[0]) begin d_req = 1'b1; d_addr = 32'h00003004; end
    else begin if_req = 1'b1; if_addr = 32'h00000104; end
    readdata = 32'hB2B2B2B2;
    ge2 = cyc + 1;
    w = int'(pick(if_req, d_req));
    chk("rr_second_model", 32'(w), 32'd1);
    sched_req(w[0], ge2, 1, td);
    drive_wait(ge2, 1, td);
    if (w[0]) d_req = 1'b0; else if_req = 1'b0;
    @(posedge clk); #1;
    readdata = 32'hC3C3C3C3;
    ge3 = cyc + 1;
    w = int'(pick(if_req, d_req));
    sched_req(w[0], ge3, 0, td);
    drive_wait(ge3, 0, td);
    if (w[0]) d_req = 1'b0; else if_req = 1'b0;
    @(posedge clk); #1;
    chk("rr1_if_done_lit", 32'(if_done_cyc), 32'(ge3 + 1));
    chk("rr2_d_done_lit", 32'(d_done_cyc), 32'(ge2 + 2));
    chk("rr_d_rdata_lit", d_rdata, 32'hB2B2B2B2);
    chk("rr_if_rdata_lit", if_rdata, 32'hC3C3C3C3);

    // Byte load, then misaligned and malformed accesses.
    run1(1'b1, 32'h00001003, 1'b0, 32'h0, 4'b1000, 32'h11223344, 0, ge, td);
    chk("lb_rdata_lit", d_rdata, 32'h11223344);
    base_rd = n_rd_cyc; base_wr = n_wr_cyc; base_flt = n_flt;
    run1(1'b1, 32'h00001002, 1'b0, 32'h0, 4'hF, 32'h55555555, 0, ge, td);
    chk("lw_misaligned_done_cyc", 32'(d_done_cyc), 32'(ge));
    run1(1'b1, 32'h00001000, 1'b1, 32'h12345678, 4'b0011, 32'h0, 0, ge, td);
    run1(1'b0, 32'h00000402, 1'b0, 32'h0, 4'hF, 32'h66666666, 0, ge, td);
    chk("fault_count", 32'(n_flt - base_flt), 32'd3);
    chk("fault_no_strobe", 32'((n_rd_cyc - base_rd) + (n_wr_cyc - base_wr)), 32'd0);
    chk("fault_d_rdata_lit", d_rdata, 32'h11223344);

    // Hung read times out, then a normal fetch.
    base_rd = n_rd_cyc; base_flt = n_flt;
    run1(1'b0, 32'h00000400, 1'b0, 32'h0, 4'hF, 32'h77777777, 10, ge, td);
    chk("timeout_latency", 32'(if_done_cyc - ge), 32'd4);
    chk("timeout_read_cycles", 32'(n_rd_cyc - base_rd), 32'd4);
    chk("timeout_fault", 32'(n_flt - base_flt), 32'd1);
    run1(1'b0, 32'h00000404, 1'b0, 32'h0, 4'hF, 32'h88888888, 0, ge, td);
    chk("after_timeout_rdata", if_rdata, 32'h88888888);

    // Reset pulsed in the middle of a waited store.
    d_req = 1'b1; d_addr = 32'h00002000; d_write = 1'b1; d_wdata = 32'h0BADF00D; d_byteen = 4'hF;
    ge = cyc + 1;
    sched_req(1'b1, ge, 10, td);
    while (cyc < ge + 2) begin
      waitrequest = (cyc >= ge);
      @(posedge clk); #1;
    end
    chk("mid_write_before_reset", 32'(write), 32'd1);
    reset = 1'b1; d_req = 1'b0; waitrequest = 1'b0;
    m_last = 1'b1;
    clear_from(cyc);
    #1;
    chk("reset_write_drop", 32'(write), 32'd0);
    chk("reset_stall_drop", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run1(1'b0, 32'h00000800, 1'b0, 32'h0, 4'hF, 32'h99999999, 1, ge, td);
    chk("post_reset_latency", 32'(if_done_cyc - ge), 32'd2);
    chk("post_reset_rdata", if_rdata, 32'h99999999);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
